// File: rtl/blokus_ctrl_pkg.sv
// Shared definitions for the Blokus turn sequencer: FSM state encoding,
// turn counter width and a small index-width helper.
package blokus_ctrl_pkg;

  localparam int TURN_CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_COLLECT  = 3'd1,
    ST_ISSUE    = 3'd2,
    ST_WAIT_RSP = 3'd3,
    ST_DRAIN    = 3'd4
  } turn_state_e;

  // Width of an index addressing `depth` entries; never below one bit.
  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/blokus_byte_buf.sv
// Small byte buffer: one synchronous write port and one combinational
// indexed read port. Contents are deliberately not reset; a packet is
// always fully written before any of it is read back.
module blokus_byte_buf
  import blokus_ctrl_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8,
  localparam int AW    = idx_w(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  // Storage is rounded up to a power of two so every index value is in range.
  logic [DATA_W-1:0] mem_r [2**AW];

  // Write port: store the presented byte at the write index.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/blokus_turn_ctrl.sv
// Blokus turn sequencer. Collects one host command packet, streams it to
// the engine with EOS on the final byte, gathers the engine's fixed-length
// reply and hands it back to the host, one turn at a time.
// Optional feature: define BLOKUS_TURN_CHKSUM_EN to expect a trailing XOR
// checksum byte after the payload; a mismatch pulses cmd_err and drops
// the packet. Without the macro cmd_err is constant 0.
module blokus_turn_ctrl
  import blokus_ctrl_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int CMD_LEN     = 4,
  parameter int RSP_LEN     = 4,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int TO_W        = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  host_wr,
  input  logic [DATA_W-1:0]     host_data,
  output logic                  host_full,
  output logic                  eng_in_en,
  output logic                  eng_in_eos,
  output logic [DATA_W-1:0]     eng_in_data,
  input  logic                  eng_in_rdy,
  output logic                  eng_out_en,
  input  logic [DATA_W-1:0]     eng_out_data,
  input  logic                  eng_out_rdy,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_data,
  input  logic                  rsp_ack,
  output logic                  busy,
  output logic                  timeout,
  output logic                  cmd_err,
  output logic [TURN_CNT_W-1:0] turn_cnt
);

  localparam int CAW = idx_w(CMD_LEN);
  localparam int RAW = idx_w(RSP_LEN);
`ifdef BLOKUS_TURN_CHKSUM_EN
  // Payload bytes 0..CMD_LEN-1 plus the checksum byte at index CMD_LEN.
  localparam int COLLECT_LAST = CMD_LEN;
`else
  localparam int COLLECT_LAST = CMD_LEN - 1;
`endif
  localparam int WW = idx_w(COLLECT_LAST + 1);

  turn_state_e           state_r;
  turn_state_e           state_nx_s;
  logic [WW-1:0]         widx_r;
  logic [CAW-1:0]        ridx_r;
  logic [RAW-1:0]        rcnt_r;
  logic [RAW-1:0]        didx_r;
  logic [TO_W-1:0]       to_cnt_r;
  logic [TURN_CNT_W-1:0] turn_cnt_r;
  logic                  timeout_r;
  logic                  cmd_err_r;
`ifdef BLOKUS_TURN_CHKSUM_EN
  logic [DATA_W-1:0]     chk_r;
`endif

  logic                  host_acc_s;
  logic                  col_last_s;
  logic                  chk_ok_s;
  logic                  cmd_we_s;
  logic                  issue_xfer_s;
  logic                  issue_last_s;
  logic                  rsp_xfer_s;
  logic                  rsp_last_s;
  logic                  to_hit_s;
  logic                  drain_xfer_s;
  logic                  drain_last_s;
  logic [DATA_W-1:0]     cmd_rd_s;
  logic [DATA_W-1:0]     rsp_rd_s;

  // Handshake decode: which transfers happen this cycle and whether they are the last.
  always_comb begin
    host_acc_s   = host_wr && ((state_r == ST_IDLE) || (state_r == ST_COLLECT));
    col_last_s   = (widx_r == WW'(COLLECT_LAST));
`ifdef BLOKUS_TURN_CHKSUM_EN
    chk_ok_s     = (host_data == chk_r);
    cmd_we_s     = host_acc_s && !col_last_s;
`else
    chk_ok_s     = 1'b1;
    cmd_we_s     = host_acc_s;
`endif
    issue_xfer_s = (state_r == ST_ISSUE) && eng_in_rdy;
    issue_last_s = (ridx_r == CAW'(CMD_LEN - 1));
    rsp_xfer_s   = (state_r == ST_WAIT_RSP) && eng_out_rdy;
    rsp_last_s   = (rcnt_r == RAW'(RSP_LEN - 1));
    // An accepted byte in the same cycle wins over the timeout.
    to_hit_s     = (state_r == ST_WAIT_RSP) && !eng_out_rdy &&
                   (to_cnt_r == TO_W'(TIMEOUT_CYC - 1));
    drain_xfer_s = (state_r == ST_DRAIN) && rsp_ack;
    drain_last_s = (didx_r == RAW'(RSP_LEN - 1));
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE, ST_COLLECT: begin
        if (host_acc_s) begin
          if (col_last_s) begin
            if (chk_ok_s) begin
              state_nx_s = ST_ISSUE;
            end else begin
              state_nx_s = ST_IDLE;
            end
          end else begin
            state_nx_s = ST_COLLECT;
          end
        end else begin
          state_nx_s = state_r;
        end
      end
      ST_ISSUE: begin
        if (issue_xfer_s && issue_last_s) begin
          state_nx_s = ST_WAIT_RSP;
        end else begin
          state_nx_s = state_r;
        end
      end
      ST_WAIT_RSP: begin
        if (rsp_xfer_s && rsp_last_s) begin
          state_nx_s = ST_DRAIN;
        end else if (to_hit_s) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = state_r;
        end
      end
      ST_DRAIN: begin
        if (drain_xfer_s && drain_last_s) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = state_r;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Indices, timeout counter, turn counter and the registered status pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      widx_r     <= {WW{1'b0}};
      ridx_r     <= {CAW{1'b0}};
      rcnt_r     <= {RAW{1'b0}};
      didx_r     <= {RAW{1'b0}};
      to_cnt_r   <= {TO_W{1'b0}};
      turn_cnt_r <= {TURN_CNT_W{1'b0}};
      timeout_r  <= 1'b0;
      cmd_err_r  <= 1'b0;
`ifdef BLOKUS_TURN_CHKSUM_EN
      chk_r      <= {DATA_W{1'b0}};
`endif
    end else begin
      if (host_acc_s) begin
        widx_r <= col_last_s ? {WW{1'b0}} : (widx_r + WW'(1'b1));
      end
`ifdef BLOKUS_TURN_CHKSUM_EN
      if (host_acc_s) begin
        chk_r <= col_last_s ? {DATA_W{1'b0}} : (chk_r ^ host_data);
      end
      cmd_err_r <= host_acc_s && col_last_s && !chk_ok_s;
`else
      cmd_err_r <= 1'b0;
`endif
      if (issue_xfer_s) begin
        ridx_r <= issue_last_s ? {CAW{1'b0}} : (ridx_r + CAW'(1'b1));
      end
      if (rsp_xfer_s) begin
        rcnt_r <= rsp_last_s ? {RAW{1'b0}} : (rcnt_r + RAW'(1'b1));
      end else if (to_hit_s) begin
        rcnt_r <= {RAW{1'b0}};
      end
      // Held at zero outside WAIT_RSP, so it is clear on entry.
      if ((state_r != ST_WAIT_RSP) || rsp_xfer_s || to_hit_s) begin
        to_cnt_r <= {TO_W{1'b0}};
      end else begin
        to_cnt_r <= to_cnt_r + TO_W'(1'b1);
      end
      if (drain_xfer_s) begin
        didx_r <= drain_last_s ? {RAW{1'b0}} : (didx_r + RAW'(1'b1));
      end
      if (drain_xfer_s && drain_last_s) begin
        turn_cnt_r <= turn_cnt_r + TURN_CNT_W'(1'b1);
      end
      timeout_r <= to_hit_s;
    end
  end

  // Output decode from state and index registers only.
  always_comb begin
    host_full   = 1'b0;
    eng_in_en   = 1'b0;
    eng_in_eos  = 1'b0;
    eng_in_data = {DATA_W{1'b0}};
    eng_out_en  = 1'b0;
    rsp_valid   = 1'b0;
    rsp_data    = {DATA_W{1'b0}};
    busy        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        busy = 1'b0;
      end
      ST_COLLECT: begin
        busy = 1'b1;
      end
      ST_ISSUE: begin
        busy        = 1'b1;
        host_full   = 1'b1;
        eng_in_en   = 1'b1;
        eng_in_eos  = issue_last_s;
        eng_in_data = cmd_rd_s;
      end
      ST_WAIT_RSP: begin
        busy       = 1'b1;
        host_full  = 1'b1;
        eng_out_en = 1'b1;
      end
      ST_DRAIN: begin
        busy      = 1'b1;
        host_full = 1'b1;
        rsp_valid = 1'b1;
        rsp_data  = rsp_rd_s;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign timeout  = timeout_r;
  assign cmd_err  = cmd_err_r;
  assign turn_cnt = turn_cnt_r;

  blokus_byte_buf #(
    .DEPTH  (CMD_LEN),
    .DATA_W (DATA_W)
  ) u_cmd_buf (
    .clk   (clk),
    .we    (cmd_we_s),
    .waddr (widx_r[CAW-1:0]),
    .wdata (host_data),
    .raddr (ridx_r),
    .rdata (cmd_rd_s)
  );

  blokus_byte_buf #(
    .DEPTH  (RSP_LEN),
    .DATA_W (DATA_W)
  ) u_rsp_buf (
    .clk   (clk),
    .we    (rsp_xfer_s),
    .waddr (rcnt_r),
    .wdata (eng_out_data),
    .raddr (didx_r),
    .rdata (rsp_rd_s)
  );

endmodule

// File: tb/tb_blokus_turn_ctrl.sv
// Self-checking bench for blokus_turn_ctrl. A turn is modelled as "the
// engine must see exactly the command bytes in order, EOS on the last, and
// the host must see exactly the reply bytes in order"; handshakes are
// randomised around that. Runs with or without BLOKUS_TURN_CHKSUM_EN.
module tb_blokus_turn_ctrl;

  localparam int DATA_W      = 8;
  localparam int CMD_LEN     = 4;
  localparam int RSP_LEN     = 4;
  localparam int TIMEOUT_CYC = 16;
  localparam int TO_W        = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        host_wr;
  logic [7:0]  host_data;
  logic        host_full;
  logic        eng_in_en;
  logic        eng_in_eos;
  logic [7:0]  eng_in_data;
  logic        eng_in_rdy;
  logic        eng_out_en;
  logic [7:0]  eng_out_data;
  logic        eng_out_rdy;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_ack;
  logic        busy;
  logic        timeout;
  logic        cmd_err;
  logic [15:0] turn_cnt;

  int errors    = 0;
  int checks    = 0;
  int exp_turns = 0;

  always #5 clk = ~clk;

  blokus_turn_ctrl #(
    .DATA_W(DATA_W), .CMD_LEN(CMD_LEN), .RSP_LEN(RSP_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC), .TO_W(TO_W)
  ) dut (
    .clk(clk), .reset(reset), .host_wr(host_wr), .host_data(host_data),
    .host_full(host_full), .eng_in_en(eng_in_en), .eng_in_eos(eng_in_eos),
    .eng_in_data(eng_in_data), .eng_in_rdy(eng_in_rdy), .eng_out_en(eng_out_en),
    .eng_out_data(eng_out_data), .eng_out_rdy(eng_out_rdy), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_ack(rsp_ack), .busy(busy), .timeout(timeout),
    .cmd_err(cmd_err), .turn_cnt(turn_cnt)
  );

  // Handshake pattern: 0 = always, 1 = 1010..., 2 = random.
  function automatic bit pick(input int mode, input int step);
    if (mode == 0) return 1'b1;
    else if (mode == 1) return ((step % 2) == 0);
    else return 1'($urandom_range(0, 1));
  endfunction

  // Drive one command packet (plus checksum when enabled); returns at the
  // negedge after the last byte with host_wr low.
  task automatic send_cmd(input logic [7:0] c [CMD_LEN], input bit gaps);
    logic [7:0] tx [$];
    logic [7:0] x;
    tx = {};
    x  = 8'h00;
    for (int i = 0; i < CMD_LEN; i++) begin
      tx.push_back(c[i]);
      x = x ^ c[i];
    end
`ifdef BLOKUS_TURN_CHKSUM_EN
    tx.push_back(x);
`endif
    foreach (tx[i]) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          host_wr = 1'b0;
        end
      end
      @(negedge clk);
      host_wr   = 1'b1;
      host_data = tx[i];
    end
    @(negedge clk);
    host_wr = 1'b0;
  endtask

  // Full turn against the reference: issue order/EOS, reply order, counters.
  task automatic do_turn(input logic [7:0] c [CMD_LEN], input logic [7:0] r [RSP_LEN],
                         input int in_mode, input int out_mode, input int ack_mode,
                         input bit poke);
    int k, j, d, cyc, stall;
    bit rdy;
    send_cmd(c, in_mode == 2);
    k = 0; cyc = 0;
    while (k < CMD_LEN && cyc < 100) begin
      checks++;
      if ({eng_in_en, eng_in_eos, eng_in_data} !== {1'b1, (k == CMD_LEN - 1), c[k]}) begin
        errors++;
        $display("FAIL issue_byte%0d: got en/eos/data=%b/%b/%h want 1/%b/%h",
                 k, eng_in_en, eng_in_eos, eng_in_data, (k == CMD_LEN - 1), c[k]);
      end
      checks++;
      if ({busy, host_full, eng_out_en} !== 3'b110) begin
        errors++;
        $display("FAIL issue_status: got busy/full/out_en=%b want 110", {busy, host_full, eng_out_en});
      end
      rdy = pick(in_mode, cyc);
      eng_in_rdy   = rdy;
      eng_out_rdy  = 1'($urandom_range(0, 1));
      eng_out_data = 8'($urandom);
      if (poke) begin
        host_wr   = 1'($urandom_range(0, 1));
        host_data = 8'h55;
      end
      @(negedge clk);
      if (rdy) k++;
      cyc++;
    end
    checks++;
    if (k != CMD_LEN) begin
      errors++;
      $display("FAIL issue_bound: got %0d bytes taken want %0d", k, CMD_LEN);
    end
    j = 0; cyc = 0; stall = 0;
    while (j < RSP_LEN && cyc < 100) begin
      checks++;
      if ({eng_out_en, eng_in_en, rsp_valid, host_full} !== 4'b1001) begin
        errors++;
        $display("FAIL wait_status: got out_en/in_en/valid/full=%b want 1001",
                 {eng_out_en, eng_in_en, rsp_valid, host_full});
      end
      rdy = pick(out_mode, cyc);
      if (stall >= 3) rdy = 1'b1;
      stall = rdy ? 0 : stall + 1;
      eng_out_rdy  = rdy;
      eng_out_data = rdy ? r[j] : 8'($urandom);
      if (poke) begin
        host_wr   = 1'($urandom_range(0, 1));
        host_data = 8'h55;
      end
      @(negedge clk);
      if (rdy) j++;
      cyc++;
    end
    checks++;
    if (j != RSP_LEN) begin
      errors++;
      $display("FAIL reply_bound: got %0d bytes want %0d", j, RSP_LEN);
    end
    eng_out_rdy  = 1'b1;
    eng_out_data = 8'hBD;
    d = 0; cyc = 0;
    while (d < RSP_LEN && cyc < 100) begin
      checks++;
      if ({rsp_valid, rsp_data} !== {1'b1, r[d]}) begin
        errors++;
        $display("FAIL drain_byte%0d: got valid/data=%b/%h want 1/%h", d, rsp_valid, rsp_data, r[d]);
      end
      checks++;
      if ({eng_out_en, busy, host_full} !== 3'b011) begin
        errors++;
        $display("FAIL drain_status: got out_en/busy/full=%b want 011", {eng_out_en, busy, host_full});
      end
      rdy = pick(ack_mode, cyc);
      rsp_ack = rdy;
      if (poke) begin
        host_wr   = 1'($urandom_range(0, 1));
        host_data = 8'h55;
      end
      @(negedge clk);
      if (rdy) d++;
      cyc++;
    end
    rsp_ack = 1'b0; host_wr = 1'b0; eng_out_rdy = 1'b0;
    exp_turns++;
    checks++;
    if (d != RSP_LEN) begin
      errors++;
      $display("FAIL drain_bound: got %0d acks want %0d", d, RSP_LEN);
    end
    checks++;
    if ({busy, host_full, rsp_valid, timeout, cmd_err} !== 5'b00000) begin
      errors++;
      $display("FAIL turn_end_status: got busy/full/valid/to/err=%b want 00000",
               {busy, host_full, rsp_valid, timeout, cmd_err});
    end
    checks++;
    if (turn_cnt !== 16'(exp_turns)) begin
      errors++;
      $display("FAIL turn_cnt: got %0d want %0d", turn_cnt, exp_turns);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; host_wr = 1'b0; host_data = 8'h00; eng_in_rdy = 1'b0;
    eng_out_rdy = 1'b0; eng_out_data = 8'h00; rsp_ack = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({host_full, eng_in_en, eng_in_eos, eng_out_en, rsp_valid, busy, timeout, cmd_err} !== 8'h00) begin
      errors++;
      $display("FAIL reset_flags: got %b want 00000000",
               {host_full, eng_in_en, eng_in_eos, eng_out_en, rsp_valid, busy, timeout, cmd_err});
    end
    checks++;
    if ({eng_in_data, rsp_data, turn_cnt} !== 32'h0) begin
      errors++;
      $display("FAIL reset_values: got %h want 0", {eng_in_data, rsp_data, turn_cnt});
    end
  endtask

  task automatic test_basic();
    logic [7:0] c [CMD_LEN];
    logic [7:0] r [RSP_LEN];
    c = '{8'h11, 8'h22, 8'h33, 8'h44};
    r = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    do_turn(c, r, 0, 0, 0, 1'b0);
  endtask

  task automatic test_rdy_toggle();
    logic [7:0] c [CMD_LEN];
    logic [7:0] r [RSP_LEN];
    for (int i = 0; i < CMD_LEN; i++) c[i] = 8'($urandom);
    for (int i = 0; i < RSP_LEN; i++) r[i] = 8'($urandom);
    do_turn(c, r, 1, 1, 1, 1'b0);
  endtask

  task automatic test_full_ignore();
    logic [7:0] c [CMD_LEN];
    logic [7:0] r [RSP_LEN];
    c = '{8'h01, 8'h80, 8'h7E, 8'hC3};
    r = '{8'h10, 8'h20, 8'h30, 8'h40};
    do_turn(c, r, 0, 2, 2, 1'b1);
    c = '{8'h9A, 8'hBC, 8'hDE, 8'hF0};
    r = '{8'h5A, 8'hA5, 8'h3C, 8'hC3};
    do_turn(c, r, 2, 2, 2, 1'b0);
  endtask

  task automatic test_timeout();
    logic [7:0] c [CMD_LEN];
    logic [7:0] r [RSP_LEN];
    int seen;
    c = '{8'h21, 8'h43, 8'h65, 8'h87};
    send_cmd(c, 1'b0);
    eng_in_rdy = 1'b1;
    repeat (CMD_LEN) @(negedge clk);
    checks++;
    if (eng_out_en !== 1'b1) begin
      errors++;
      $display("FAIL to_wait_entry: got eng_out_en=%b want 1", eng_out_en);
    end
    eng_out_rdy = 1'b1; eng_out_data = 8'hC1;
    @(negedge clk);
    eng_out_data = 8'hC2;
    @(negedge clk);
    eng_out_rdy = 1'b0;
    seen = -1;
    for (int n = 0; n <= 40; n++) begin
      if (timeout === 1'b1) begin
        seen = n;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (seen != TIMEOUT_CYC) begin
      errors++;
      $display("FAIL timeout_delay: got %0d cycles want %0d", seen, TIMEOUT_CYC);
    end
    checks++;
    if ({busy, eng_out_en, rsp_valid, host_full} !== 4'b0000 || turn_cnt !== 16'(exp_turns)) begin
      errors++;
      $display("FAIL timeout_state: got busy/out_en/valid/full=%b cnt=%0d want 0000 cnt=%0d",
               {busy, eng_out_en, rsp_valid, host_full}, turn_cnt, exp_turns);
    end
    @(negedge clk);
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse: got %b want 0", timeout);
    end
    r = '{8'hD1, 8'hD2, 8'hD3, 8'hD4};
    do_turn(c, r, 0, 0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [7:0] c [CMD_LEN];
    logic [7:0] r [RSP_LEN];
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < CMD_LEN; i++) c[i] = 8'($urandom);
      for (int i = 0; i < RSP_LEN; i++) r[i] = 8'($urandom);
      do_turn(c, r, (t == 0) ? 0 : 2, 2, (t < 2) ? 0 : 2, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] c [CMD_LEN];
    logic [7:0] r [RSP_LEN];
    c = '{8'hE1, 8'hE2, 8'hE3, 8'hE4};
    send_cmd(c, 1'b0);
    eng_in_rdy = 1'b1;
    repeat (CMD_LEN - 1) @(negedge clk);
    checks++;
    if ({eng_in_en, eng_in_eos, eng_in_data} !== {2'b11, 8'hE4}) begin
      errors++;
      $display("FAIL pre_reset_eos: got %b/%b/%h want 1/1/e4", eng_in_en, eng_in_eos, eng_in_data);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({eng_in_en, eng_in_eos, busy, host_full, turn_cnt} !== 20'h0) begin
      errors++;
      $display("FAIL mid_reset: got en/eos/busy/full=%b cnt=%0d want 0000 cnt=0",
               {eng_in_en, eng_in_eos, busy, host_full}, turn_cnt);
    end
    @(negedge clk);
    reset = 1'b0;
    exp_turns = 0;
    @(negedge clk);
    checks++;
    if ({eng_in_en, busy} !== 2'b00) begin
      errors++;
      $display("FAIL post_reset_idle: got en/busy=%b want 00", {eng_in_en, busy});
    end
    c = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};
    r = '{8'hF1, 8'hF2, 8'hF3, 8'hF4};
    do_turn(c, r, 0, 0, 0, 1'b0);
  endtask

  task automatic test_chksum();
`ifdef BLOKUS_TURN_CHKSUM_EN
    logic [7:0] c [CMD_LEN];
    logic [7:0] r [RSP_LEN];
    logic [7:0] bad [5];
    bit en_seen;
    c = '{8'h01, 8'h02, 8'h04, 8'h08};
    r = '{8'h61, 8'h62, 8'h63, 8'h64};
    do_turn(c, r, 0, 0, 0, 1'b0);
    bad = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h0E};
    en_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      host_wr = 1'b1; host_data = bad[i];
    end
    @(negedge clk);
    host_wr = 1'b0;
    checks++;
    if ({cmd_err, busy, eng_in_en} !== 3'b100) begin
      errors++;
      $display("FAIL chk_bad: got err/busy/en=%b want 100", {cmd_err, busy, eng_in_en});
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (eng_in_en === 1'b1 || cmd_err === 1'b1) en_seen = 1'b1;
    end
    checks++;
    if (en_seen) begin
      errors++;
      $display("FAIL chk_bad_quiet: got en/err activity=1 want 0");
    end
`else
    // Without the checksum feature a fifth host byte starts a new packet.
    checks++;
    if (cmd_err !== 1'b0) begin
      errors++;
      $display("FAIL cmd_err_tied: got %b want 0", cmd_err);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rdy_toggle();
    test_full_ignore();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_chksum();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
